// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
//   state_t       - controller state encoding (idle, run, done)
//   DEFAULT_WIDTH - default operand width
//   cnt_width()   - bit counter width for a given operand width
package serial_add_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Counter must index bits 0..w-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/FullAdd.sv
// One-bit full adder cell.
//   a, b, ci : operand bits and carry in
//   s, co    : sum bit and carry out
module FullAdd (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a
// single full-adder cell.
//   CLK, RST           : clock, synchronous active-high reset
//   START, SUB         : begin operation (sampled in idle), 1 = A-B
//   A, B, C_in         : operands and add carry-in, captured with START
//   BUSY               : operation in progress (run or done)
//   DONE               : one-cycle pulse, results valid
//   SUM, C_out, OVF    : result, final carry, signed overflow (held)
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             SUB,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_in,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SUM,
   output logic             C_out,
   output logic             OVF
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_t           state_q;
   state_t           state_nx;
   logic [WIDTH-1:0] sa_q;
   logic [WIDTH-1:0] sb_q;
   logic [WIDTH-1:0] res_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic             fa_s;
   logic             fa_co;
   logic             accept_c;
   logic             last_c;

   // The only arithmetic in the datapath.
   FullAdd u_fa (
      .a  (sa_q[0]),
      .b  (sb_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // Next-state decode.
   always_comb begin
      state_nx = state_q;
      accept_c = 1'b0;
      last_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_nx = ST_RUN;
               accept_c = 1'b1;
            end
         end
         ST_RUN: begin
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_nx = ST_DONE;
               last_c   = 1'b1;
            end
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_nx;
   end

   // Datapath and registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sa_q    <= '0;
         sb_q    <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         SUM     <= '0;
         C_out   <= 1'b0;
         OVF     <= 1'b0;
      end else begin
         BUSY <= (state_nx != ST_IDLE);
         DONE <= (state_nx == ST_DONE);
         if (accept_c) begin
            // Subtraction is A + ~B + 1.
            sa_q    <= A;
            sb_q    <= SUB ? ~B : B;
            carry_q <= SUB ? 1'b1 : C_in;
            res_q   <= '0;
            cnt_q   <= '0;
         end else if (state_q == ST_RUN) begin
            sa_q    <= {1'b0, sa_q[WIDTH-1:1]};
            sb_q    <= {1'b0, sb_q[WIDTH-1:1]};
            res_q   <= {fa_s, res_q[WIDTH-1:1]};
            carry_q <= fa_co;
            cnt_q   <= cnt_q + CW'(1);
         end
         // Outputs only change when the full result is available.
         if (last_c) begin
            SUM   <= {fa_s, res_q[WIDTH-1:1]};
            C_out <= fa_co;
            OVF   <= carry_q ^ fa_co;
         end
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed vectors with
// literal expectations plus randomized traffic against a behavioural model.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         c_out;
   logic         ovf;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_done = -1;
   bit chk_en = 1'b0;

   // Behavioural model state.
   int           m_left = 0;   // cycles of busy remaining
   logic [W-1:0] m_sum  = '0;
   logic         m_cout = 1'b0;
   logic         m_ovf  = 1'b0;
   logic         p_sub;
   logic [W-1:0] p_a;
   logic [W-1:0] p_b;
   logic         p_cin;
   int           n_acc = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .CLK   (clk),
      .RST   (rst),
      .START (start),
      .SUB   (sub),
      .A     (a),
      .B     (b),
      .C_in  (c_in),
      .BUSY  (busy),
      .DONE  (done),
      .SUM   (sum),
      .C_out (c_out),
      .OVF   (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Result from integer arithmetic: {C_out, OVF, SUM}.
   function automatic logic [W+1:0] ref_calc(input logic s, input logic [W-1:0] x,
                                             input logic [W-1:0] y, input logic ci);
      int sx, sy, sr;
      logic [W-1:0] r;
      logic co, ov;
      sx = x[W-1] ? int'(x) - 256 : int'(x);
      sy = y[W-1] ? int'(y) - 256 : int'(y);
      if (s) begin
         r  = W'(int'(x) - int'(y));
         co = (x >= y);
         sr = sx - sy;
      end else begin
         r  = W'(int'(x) + int'(y) + int'(ci));
         co = (int'(x) + int'(y) + int'(ci)) > 255;
         sr = sx + sy + int'(ci);
      end
      ov = (sr > 127) || (sr < -128);
      return {co, ov, r};
   endfunction

   // Model: accept in idle, results appear WIDTH edges later for one cycle.
   always @(posedge clk) begin
      logic [W+1:0] r;
      if (rst) begin
         m_left = 0;
         m_sum  = '0;
         m_cout = 1'b0;
         m_ovf  = 1'b0;
      end else if (m_left == 0) begin
         if (start) begin
            p_sub  = sub;
            p_a    = a;
            p_b    = b;
            p_cin  = c_in;
            m_left = W + 1;
            n_acc++;
         end
      end else begin
         m_left--;
         if (m_left == 1) begin
            r = ref_calc(p_sub, p_a, p_b, p_cin);
            m_sum  = r[W-1:0];
            m_ovf  = r[W];
            m_cout = r[W+1];
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         cyc++;
         chk("busy", 32'(busy), 32'(m_left > 0));
         chk("done", 32'(done), 32'(m_left == 1));
         chk("sum", 32'(sum), 32'(m_sum));
         chk("c_out", 32'(c_out), 32'(m_cout));
         chk("ovf", 32'(ovf), 32'(m_ovf));
         if (done) begin
            if (last_done >= 0) chk("done_gap", 32'((cyc - last_done) >= 10), 32'd1);
            last_done = cyc;
         end
      end
   end

   // Run one operation from idle and check against literal expectations.
   task automatic do_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic [W-1:0] es, input logic ec,
                        input logic eo);
      int n;
      sub = s; a = x; b = y; c_in = ci; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom); c_in = 1'($urandom);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 20);
      chk("latency", 32'(n), 32'd9);
      chk("op_sum", 32'(sum), 32'(es));
      chk("op_cout", 32'(c_out), 32'(ec));
      chk("op_ovf", 32'(ovf), 32'(eo));
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      int base;
      int budget;
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; c_in = 1'b0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(c_out), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed vectors; the first START lands on the first edge out of reset.
      do_op(1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
      do_op(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      do_op(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      do_op(1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
      do_op(1'b1, 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0);
      do_op(1'b0, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);
      do_op(1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);

      // START during RUN and during DONE is ignored.
      sub = 1'b0; a = 8'h0F; b = 8'h01; c_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      start = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      chk("ign_done", 32'(done), 32'd1);
      chk("ign_sum", 32'(sum), 32'h10);
      start = 1'b1; a = 8'h33; b = 8'h44; sub = 1'b0;
      @(posedge clk); #1;
      chk("ign_idle_busy", 32'(busy), 32'd0);
      a = 8'h21; b = 8'h11; c_in = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 20);
      chk("next_latency", 32'(n), 32'd9);
      chk("next_sum", 32'(sum), 32'h32);
      @(posedge clk); #1;

      // Reset in the 4th RUN cycle discards the operation.
      sub = 1'b0; a = 8'h77; b = 8'h11; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      repeat (12) begin
         @(negedge clk);
         chk("abort_no_done", 32'(done), 32'd0);
      end
      @(posedge clk); #1;
      do_op(1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

      // Randomized traffic, with occasional resets.
      base = n_acc;
      budget = 0;
      while ((n_acc - base) < 1000 && budget < 30000) begin
         rst   = ($urandom_range(0, 299) == 0);
         start = ($urandom_range(0, 3) != 0);
         sub   = 1'($urandom);
         a     = W'($urandom);
         b     = W'($urandom);
         c_in  = 1'($urandom);
         @(posedge clk); #1;
         budget++;
      end
      rst = 1'b0;
      start = 1'b0;
      chk("rand_ops", 32'((n_acc - base) >= 1000), 32'd1);
      repeat (12) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
